rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//  Power-up / soft-reset sequencer for the audio core. Sits behind the per-domain reset synchronizers.
//  Holds all domain resets asserted until the clock source is stable. Then releases them one by one,
//  in fixed order (e.g. clock gen -> I2S -> DSP -> host IF), spaced by a programmable gap.
//  Also services a soft-reset request with a four-phase REQ/ACK handshake.
// PARAMETERS
//  NUM_DOMAINS  4   number of reset domains sequenced (>=1)
//  CNT_WIDTH    8   width of internal delay counter
//  HOLD_CYCLES  16  cycles all resets stay asserted after LOCK_I seen high (1..2**CNT_WIDTH-1)
//  STEP_CYCLES  8   cycles between consecutive domain release/assert events (1..2**CNT_WIDTH-1)
// PORTS
//  CLK_I       in   1            single clock; all logic on posedge
//  RST_I       in   1            synchronous reset, active-high
//  LOCK_I      in   1            clock-source stable (pre-synchronized to CLK_I), level
//  SRST_REQ_I  in   1            soft-reset request, level; held until SRST_ACK_O seen
//  SRST_ACK_O  out  1            soft-reset acknowledge: all domains are in reset
//  NRST_O      out  NUM_DOMAINS  per-domain reset, active-low; bit 0 released first
//  READY_O     out  1            all domains released, sequencer in RUN
//  STATE_O     out  3            debug: 0 ASSERT, 1 HOLD, 2 RELEASE, 3 RUN, 4 SRST
// BEHAVIOUR
//  - All outputs registered. RST_I high at a posedge gives: state ASSERT, NRST_O='0, READY_O=0,
//    SRST_ACK_O=0, STATE_O=0, counter=0, domain index=0. RST_I overrides everything, mid-sequence too.
//  - ASSERT: NRST_O='0. LOCK_I=1 -> HOLD at the next edge with counter cleared.
//  - HOLD: counts HOLD_CYCLES edges. On the edge the count completes:
//      NRST_O[0]<=1, state RELEASE, index=1.
//    Sampling LOCK_I=1 at edge k in ASSERT gives NRST_O[0] rising at edge k+HOLD_CYCLES.
//  - RELEASE: NRST_O[i] rises exactly STEP_CYCLES edges after NRST_O[i-1].
//    The edge that releases NRST_O[NUM_DOMAINS-1] also sets READY_O=1 and enters RUN.
//    NUM_DOMAINS=1: HOLD goes straight to RUN, with READY_O rising together with NRST_O[0].
//  - Released bits never drop except on: LOCK loss, soft reset, or RST_I.
//  - RUN: READY_O=1, NRST_O='1. SRST_REQ_I=1 -> SRST.
//    If SRST_REQ_I is already high when RUN is reached, SRST is entered on the next edge.
//  - SRST (default): the entry edge sets NRST_O='0, READY_O=0, SRST_ACK_O=1.
//    Stays in SRST while SRST_REQ_I=1.
//    SRST_REQ_I=0 -> the next edge clears SRST_ACK_O and enters HOLD, so the normal release sequence repeats.
//  - SRST_REQ_I is ignored in ASSERT/HOLD/RELEASE (no ACK is issued). It is latched by level only in RUN.
//  - LOCK_I=0 in any state except ASSERT -> the next edge enters ASSERT.
//    That edge sets NRST_O='0, READY_O=0, SRST_ACK_O=0, counter=0. LOCK loss has priority over SRST_REQ_I.
//  - Counter: saturating compare against HOLD_CYCLES-1 / STEP_CYCLES-1; cleared on every state change.
//    No wrap-around is possible within the legal parameter range.
// CONFIGURATION
//  RST_SEQ_REVERSE_EN
//  - Undefined: soft reset asserts all domains on the same edge, as above.
//  - Defined: SRST entry edge clears only NRST_O[NUM_DOMAINS-1] and READY_O.
//    Each further lower bit clears STEP_CYCLES edges later.
//    The edge that clears NRST_O[0] sets SRST_ACK_O=1.
//    Dropping SRST_REQ_I before ACK has no effect; the drain always completes.
//    LOCK loss still forces ASSERT immediately. The power-up release order is unchanged.
// TESTING (NUM_DOMAINS=4, HOLD_CYCLES=16, STEP_CYCLES=8; edge 1 = first edge with RST_I=0)
//  1. LOCK_I=1 throughout -> NRST_O[0..3] rise at edges 17/25/33/41. READY_O=1 at edge 41.
//     STATE_O: 1 at edge 1, 2 at edge 17, 3 at edge 41.
//  2. LOCK_I=0 until edge 10, then 1 -> NRST_O stays 4'b0000 through edge 9. NRST_O[0] rises at edge 26.
//  3. In RUN, raise SRST_REQ_I at edge 100 -> NRST_O=4'b0000 and SRST_ACK_O=1 at edge 100.
//     Drop REQ at edge 105 -> ACK=0 at edge 105. NRST_O[0] rises at edge 121, READY_O at edge 145.
//  4. LOCK_I drops at edge 30, during RELEASE with 4'b0011 -> 4'b0000 and STATE_O=0 at edge 30.
//     LOCK_I back at edge 35 -> NRST_O[0] rises at edge 51.
//  5. RST_I pulsed high at edge 200 during SRST with ACK=1 -> all outputs at reset values at edge 200.
//     Sequence restarts as in test 1.
//  6. RST_SEQ_REVERSE_EN defined, REQ raised at edge 100 in RUN -> NRST_O 4'b0111@100, 4'b0011@108,
//     4'b0001@116, 4'b0000@124. SRST_ACK_O=1 at edge 124.

Source files
------------

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - reset sequencer control/status bundle
//
// Purpose: groups the lock input, the soft-reset REQ/ACK handshake and the
// per-domain reset / status outputs of rst_sequencer.
// Signals:
//   LOCK_I      clock source stable, level, synchronous to CLK_I
//   SRST_REQ_I  soft-reset request, level, held until SRST_ACK_O is seen
//   SRST_ACK_O  soft-reset acknowledge (all domains held in reset)
//   NRST_O      per-domain active-low reset, bit 0 released first
//   READY_O     all domains released, sequencer in RUN
//   STATE_O     debug state code (0 ASSERT,1 HOLD,2 RELEASE,3 RUN,4 SRST)
// Modports: master = environment driving lock/request,
//           slave  = the sequencer itself.
interface rst_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   LOCK_I;
  logic                   SRST_REQ_I;
  logic                   SRST_ACK_O;
  logic [NUM_DOMAINS-1:0] NRST_O;
  logic                   READY_O;
  logic [2:0]             STATE_O;

  modport master (
    output LOCK_I, SRST_REQ_I,
    input  SRST_ACK_O, NRST_O, READY_O, STATE_O
  );

  modport slave (
    input  LOCK_I, SRST_REQ_I,
    output SRST_ACK_O, NRST_O, READY_O, STATE_O
  );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - power-up / soft-reset sequencer for the audio core
//
// Purpose: holds every domain reset asserted until the clock source locks,
// waits HOLD_CYCLES, then releases the domains one at a time in bit order
// spaced by STEP_CYCLES. In RUN a soft-reset request puts all domains back
// into reset and acknowledges; dropping the request restarts the release.
// Ports:
//   CLK_I  in  single clock, posedge
//   RST_I  in  synchronous reset, active-high
//   bus    slave modport of rst_sequencer_if (lock, REQ/ACK, resets, status)
// Optional feature macro: RST_SEQ_REVERSE_EN
//   When defined, soft reset drains the domains in reverse order (top bit
//   first, STEP_CYCLES apart) and ACK rises with the clearing of bit 0.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  rst_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STEP_LAST = CNT_WIDTH'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SRST    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] nrst_q, nrst_d;
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      nrst_q  <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    ready_d = ready_q;
    ack_d   = ack_q;

    // Lock loss wins over everything else, including a pending soft reset.
    if (state_q != ST_ASSERT && !bus.LOCK_I) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      nrst_d  = '0;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          nrst_d  = '0;
          ready_d = 1'b0;
          ack_d   = 1'b0;
          if (bus.LOCK_I) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end

        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            nrst_d[0] = 1'b1;
            cnt_d     = '0;
            if (NUM_DOMAINS == 1) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d   = IDX_W'(1);
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == STEP_LAST) begin
            nrst_d[idx_q] = 1'b1;
            cnt_d         = '0;
            if (idx_q == IDX_LAST) begin
              ready_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.SRST_REQ_I) begin
            state_d = ST_SRST;
            cnt_d   = '0;
            ready_d = 1'b0;
`ifdef RST_SEQ_REVERSE_EN
            // Start the drain at the top bit; idx points at the bit just cleared.
            nrst_d[NUM_DOMAINS-1] = 1'b0;
            idx_d                 = IDX_LAST;
            ack_d                 = (NUM_DOMAINS == 1);
`else
            nrst_d = '0;
            ack_d  = 1'b1;
`endif
          end
        end

        ST_SRST: begin
`ifdef RST_SEQ_REVERSE_EN
          // The drain runs to completion regardless of the request level.
          if (!ack_q) begin
            if (cnt_q == STEP_LAST) begin
              nrst_d[idx_q - IDX_W'(1)] = 1'b0;
              idx_d                     = idx_q - IDX_W'(1);
              cnt_d                     = '0;
              ack_d                     = (idx_q == IDX_W'(1));
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (!bus.SRST_REQ_I) begin
            ack_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_HOLD;
          end
`else
          if (!bus.SRST_REQ_I) begin
            ack_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_HOLD;
          end
`endif
        end

        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          idx_d   = '0;
          nrst_d  = '0;
          ready_d = 1'b0;
          ack_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.NRST_O     = nrst_q;
  assign bus.READY_O    = ready_q;
  assign bus.SRST_ACK_O = ack_q;
  assign bus.STATE_O    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer
module tb_rst_sequencer;

  logic CLK_I = 1'b0;
  logic RST_I;

  rst_sequencer_if #(.NUM_DOMAINS(4)) bus ();

  rst_sequencer #(
    .NUM_DOMAINS(4),
    .CNT_WIDTH  (8),
    .HOLD_CYCLES(16),
    .STEP_CYCLES(8)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus.slave)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp  = 0;
  int n_fail = 0;
  int e      = 0;

  task automatic tick();
    @(posedge CLK_I);
    #2;
    e = e + 1;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] nrst, input logic rdy,
                           input logic ack, input logic [2:0] st);
    check({tag, ".nrst"},  32'(bus.NRST_O),     32'(nrst));
    check({tag, ".ready"}, 32'(bus.READY_O),    32'(rdy));
    check({tag, ".ack"},   32'(bus.SRST_ACK_O), 32'(ack));
    check({tag, ".state"}, 32'(bus.STATE_O),    32'(st));
  endtask

  task automatic do_reset(input logic lock);
    RST_I          = 1'b1;
    bus.LOCK_I     = lock;
    bus.SRST_REQ_I = 1'b0;
    tick();
    tick();
    RST_I = 1'b0;
    e     = 0;
  endtask

  initial begin
    // Reset state, then test 1: LOCK held high from the start.
    do_reset(1'b1);
    check_all("rst", 4'b0000, 1'b0, 1'b0, 3'd0);
    run_to(1);   check_all("t1.e1",  4'b0000, 1'b0, 1'b0, 3'd1);
    run_to(16);  check_all("t1.e16", 4'b0000, 1'b0, 1'b0, 3'd1);
    run_to(17);  check_all("t1.e17", 4'b0001, 1'b0, 1'b0, 3'd2);
    run_to(24);  check("t1.e24", 32'(bus.NRST_O), 32'h1);
    run_to(25);  check("t1.e25", 32'(bus.NRST_O), 32'h3);
    run_to(33);  check("t1.e33", 32'(bus.NRST_O), 32'h7);
    run_to(40);  check_all("t1.e40", 4'b0111, 1'b0, 1'b0, 3'd2);
    run_to(41);  check_all("t1.e41", 4'b1111, 1'b1, 1'b0, 3'd3);

    // Test 3: soft reset from RUN.
    run_to(99);  bus.SRST_REQ_I = 1'b1;
`ifdef RST_SEQ_REVERSE_EN
    run_to(100); check_all("t6.e100", 4'b0111, 1'b0, 1'b0, 3'd4);
    run_to(104); bus.SRST_REQ_I = 1'b0;
    run_to(107); check("t6.e107", 32'(bus.NRST_O), 32'h7);
    run_to(108); check("t6.e108", 32'(bus.NRST_O), 32'h3);
    run_to(116); check_all("t6.e116", 4'b0001, 1'b0, 1'b0, 3'd4);
    run_to(124); check_all("t6.e124", 4'b0000, 1'b0, 1'b1, 3'd4);
    run_to(125); check_all("t6.e125", 4'b0000, 1'b0, 1'b0, 3'd1);
    run_to(141); check("t6.e141", 32'(bus.NRST_O), 32'h1);
    run_to(165); check_all("t6.e165", 4'b1111, 1'b1, 1'b0, 3'd3);
`else
    run_to(100); check_all("t3.e100", 4'b0000, 1'b0, 1'b1, 3'd4);
    run_to(104); check("t3.e104.ack", 32'(bus.SRST_ACK_O), 32'h1);
    bus.SRST_REQ_I = 1'b0;
    run_to(105); check_all("t3.e105", 4'b0000, 1'b0, 1'b0, 3'd1);
    run_to(120); check("t3.e120", 32'(bus.NRST_O), 32'h0);
    run_to(121); check_all("t3.e121", 4'b0001, 1'b0, 1'b0, 3'd2);
    run_to(144); check("t3.e144.ready", 32'(bus.READY_O), 32'h0);
    run_to(145); check_all("t3.e145", 4'b1111, 1'b1, 1'b0, 3'd3);
`endif

    // Test 5: RST_I pulse while sitting in SRST with ACK high.
    run_to(169); bus.SRST_REQ_I = 1'b1;
    run_to(199); check("t5.e199.ack", 32'(bus.SRST_ACK_O), 32'h1);
    RST_I = 1'b1;
    run_to(200); check_all("t5.e200", 4'b0000, 1'b0, 1'b0, 3'd0);
    RST_I = 1'b0;
    bus.SRST_REQ_I = 1'b0;
    e = 0;
    run_to(1);   check("t5.e1.state", 32'(bus.STATE_O), 32'd1);
    run_to(17);  check("t5.e17", 32'(bus.NRST_O), 32'h1);
    run_to(41);  check_all("t5.e41", 4'b1111, 1'b1, 1'b0, 3'd3);

    // Test 2: LOCK arrives late.
    do_reset(1'b0);
    run_to(9);   check_all("t2.e9", 4'b0000, 1'b0, 1'b0, 3'd0);
    bus.LOCK_I = 1'b1;
    run_to(10);  check("t2.e10.state", 32'(bus.STATE_O), 32'd1);
    run_to(25);  check("t2.e25", 32'(bus.NRST_O), 32'h0);
    run_to(26);  check("t2.e26", 32'(bus.NRST_O), 32'h1);

    // Test 4: LOCK loss mid-release, with REQ ignored during the following HOLD.
    do_reset(1'b1);
    run_to(29);  check_all("t4.e29", 4'b0011, 1'b0, 1'b0, 3'd2);
    bus.LOCK_I = 1'b0;
    run_to(30);  check_all("t4.e30", 4'b0000, 1'b0, 1'b0, 3'd0);
    run_to(34);  check("t4.e34.state", 32'(bus.STATE_O), 32'd0);
    bus.LOCK_I = 1'b1;
    run_to(35);  check("t4.e35.state", 32'(bus.STATE_O), 32'd1);
    bus.SRST_REQ_I = 1'b1;
    run_to(40);  check_all("t4.e40", 4'b0000, 1'b0, 1'b0, 3'd1);
    bus.SRST_REQ_I = 1'b0;
    run_to(50);  check("t4.e50", 32'(bus.NRST_O), 32'h0);
    run_to(51);  check_all("t4.e51", 4'b0001, 1'b0, 1'b0, 3'd2);

    // Lock loss has priority over a held soft-reset request.
    run_to(75);  check("pri.e75.ready", 32'(bus.READY_O), 32'h1);
    bus.SRST_REQ_I = 1'b1;
    bus.LOCK_I     = 1'b0;
    run_to(76);  check_all("pri.e76", 4'b0000, 1'b0, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
